// File: rtl/axis_cmd_pkg.sv
// Shared definitions for the axis_cmd command sequencer: 3-bit state
// encoding and transfer direction constants.
// No ports; imported by axis_cmd and axis_cmd_cnt.
package axis_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_GO   = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

endpackage

// File: rtl/axis_cmd_cnt.sv
// Beat counter for completion tracking: load, decrement, zero flag.
// Latency: count updates on the clock edge after load/dec; zero is combinational.
// Ports: clk, rst (async active-low), load, dec, load_val in; count, zero out.
// Only built when AXIS_CMD_DONE_EN is defined, since nothing else uses it.
`ifdef AXIS_CMD_DONE_EN
module axis_cmd_cnt
  import axis_cmd_pkg::*;
#(
  parameter int LEN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [LEN_WIDTH-1:0] load_val,
  output logic [LEN_WIDTH-1:0] count,
  output logic                 zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      // Saturate at zero so stray monitor pulses can never wrap the count.
      count <= count - LEN_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`endif

// File: rtl/axis_cmd.sv
// Command sequencer: turns one {dir, addr, len} command into three cfg-bus
// writes (start address, length, go) toward an AXI stream engine.
// Latency: cfg beats on cycles +1..+3 after acceptance; no cfg backpressure,
// cmd_ready is high only in IDLE.
// Ports: clk, rst (async active-low); cmd_* command handshake; cfg_* write
// strobe bus; wr_mon/rd_mon stream handshake monitors; wr_done/rd_done pulses;
// busy.
// Build option AXIS_CMD_DONE_EN: adds the WAIT state, beat counter and done
// pulses. Without it GO returns straight to IDLE and the done outputs are 0.
module axis_cmd
  import axis_cmd_pkg::*;
#(
  parameter int CFG_ID_WR  = 1,
  parameter int CFG_ID_RD  = 2,
  parameter int CFG_ADDR   = 23,
  parameter int CFG_DATA   = 24,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_dir,
  input  logic [CFG_DWIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  input  logic                  wr_mon,
  input  logic                  rd_mon,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  busy
);

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  lat_dir;
  logic [CFG_DWIDTH-1:0] lat_addr;
  logic [LEN_WIDTH-1:0]  lat_len;

  assign accept = cmd_valid && (state == ST_IDLE);

  // Command latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_dir  <= DIR_WR;
      lat_addr <= '0;
      lat_len  <= '0;
    end else if (accept) begin
      lat_dir  <= cmd_dir;
      lat_addr <= cmd_addr;
      lat_len  <= cmd_len;
    end
  end

`ifdef AXIS_CMD_DONE_EN
  logic                 mon_sel;
  logic                 cnt_dec;
  logic                 cnt_last;
  logic [LEN_WIDTH-1:0] cnt_count;
  logic                 cnt_zero;

  // Only the monitor of the issued direction advances the count.
  assign mon_sel  = (lat_dir == DIR_RD) ? rd_mon : wr_mon;
  assign cnt_dec  = (state == ST_WAIT) && mon_sel;
  // The final beat is the decrement from 1 to 0; leave WAIT on that edge so
  // the done pulse and IDLE coincide in the next cycle.
  assign cnt_last = cnt_dec && (cnt_count == LEN_WIDTH'(1));

  axis_cmd_cnt #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_GO),
    .dec      (cnt_dec),
    .load_val (lat_len),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // Done pulses: either a zero-length command (no cfg beats, completes
  // immediately) or the last tracked beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (accept && (cmd_len == '0)) begin
        wr_done <= (cmd_dir == DIR_WR);
        rd_done <= (cmd_dir == DIR_RD);
      end else if (cnt_last) begin
        wr_done <= (lat_dir == DIR_WR);
        rd_done <= (lat_dir == DIR_RD);
      end
    end
  end
`else
  logic unused_mon;
  assign unused_mon = wr_mon ^ rd_mon;
  assign wr_done    = 1'b0;
  assign rd_done    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && (cmd_len != '0)) begin
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: state_nxt = ST_LEN;
      ST_LEN:  state_nxt = ST_GO;
`ifdef AXIS_CMD_DONE_EN
      ST_GO:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        // cnt_zero only guards against a count that can never finish.
        if (cnt_last || cnt_zero) begin
          state_nxt = ST_IDLE;
        end
      end
`else
      ST_GO:   state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic, decoded straight from state so reset clears it at once.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    case (state)
      ST_ADDR: begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(CFG_ADDR);
        cfg_data  = lat_addr;
      end
      ST_LEN: begin
        cfg_valid = 1'b1;
        cfg_addr  = CFG_AWIDTH'(CFG_DATA);
        cfg_data  = CFG_DWIDTH'(lat_len);
      end
      ST_GO: begin
        cfg_valid = 1'b1;
        cfg_addr  = (lat_dir == DIR_RD) ? CFG_AWIDTH'(CFG_ID_RD) : CFG_AWIDTH'(CFG_ID_WR);
        cfg_data  = CFG_DWIDTH'(1);
      end
      default: ;
    endcase
  end

endmodule
